// File: rtl/psram_spi_responder.sv
// rtl/psram_spi_responder.sv - SPI-slave PSRAM model for psram_bridge loopback (fast read 0x0B under PSRAM_FAST_READ_EN)
module psram_spi_responder #(
    parameter int MEM_ADDR_W   = 10,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  chip_enable,
    input  logic                  serial_in,
    output logic                  serial_out,
    input  logic [MEM_ADDR_W-1:0] bd_addr,
    output logic [7:0]            bd_data,
    output logic                  busy,
    output logic                  bad_cmd,
    output logic [15:0]           byte_count
);
    // Shifter is just wide enough for the kept address bits or an opcode byte.
    localparam int SR_W = (MEM_ADDR_W > 8 ? MEM_ADDR_W : 8) - 1;

    if (MEM_ADDR_W < 2 || DUMMY_CYCLES < 1) begin : g_bad_params
        $error("psram_spi_responder: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WRITE, READ, IGNORE
`ifdef PSRAM_FAST_READ_EN
        , DUMMY
`endif
    } state_t;

    state_t                state;
    logic [1:0]            sclk_s, ce_s, mosi_s;
    logic                  sclk_d;
    logic                  armed;
    logic                  is_write;
    logic [4:0]            bit_cnt;
    logic [SR_W-1:0]       sr;
    logic [6:0]            tx;
    logic [MEM_ADDR_W-1:0] ptr;
    logic [7:0]            rd_q;
    logic [7:0]            mem [2**MEM_ADDR_W];
`ifdef PSRAM_FAST_READ_EN
    logic                  is_fast;
    logic [15:0]           dummy_cnt;
`endif

    logic       rise, fall, ce_n, mosi, wr_en;
    logic [7:0] rx_byte;
    logic [15:0] count_inc;

    assign rise      = sclk_s[1] & ~sclk_d;
    assign fall      = ~sclk_s[1] & sclk_d;
    assign ce_n      = ce_s[1];
    assign mosi      = mosi_s[1];
    assign rx_byte   = {sr[6:0], mosi};
    assign count_inc = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
    assign wr_en     = ~reset & ~ce_n & (state == WRITE) & rise & (bit_cnt == 5'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            // ce sync clears low so a select held through reset must be released before re-arming
            sclk_s     <= '0;
            ce_s       <= '0;
            mosi_s     <= '0;
            sclk_d     <= 1'b0;
            armed      <= 1'b0;
            state      <= IDLE;
            is_write   <= 1'b0;
            bit_cnt    <= '0;
            sr         <= '0;
            tx         <= '0;
            ptr        <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            bad_cmd    <= 1'b0;
            byte_count <= '0;
`ifdef PSRAM_FAST_READ_EN
            is_fast    <= 1'b0;
            dummy_cnt  <= '0;
`endif
        end else begin
            sclk_s  <= {sclk_s[0], sclk};
            ce_s    <= {ce_s[0], chip_enable};
            mosi_s  <= {mosi_s[0], serial_in};
            sclk_d  <= sclk_s[1];
            bad_cmd <= 1'b0;
            if (ce_n) begin
                state      <= IDLE;
                armed      <= 1'b1;
                busy       <= 1'b0;
                serial_out <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: if (armed) begin
                        state      <= CMD;
                        bit_cnt    <= '0;
                        byte_count <= '0;
                        busy       <= 1'b1;
                    end
                    CMD: if (rise) begin
                        sr <= {sr[SR_W-2:0], mosi};
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            case (rx_byte)
                                8'h02: begin state <= ADDR; is_write <= 1'b1; end
                                8'h03: begin state <= ADDR; is_write <= 1'b0; end
`ifdef PSRAM_FAST_READ_EN
                                8'h0B: begin state <= ADDR; is_write <= 1'b0; end
`endif
                                default: begin state <= IGNORE; bad_cmd <= 1'b1; end
                            endcase
`ifdef PSRAM_FAST_READ_EN
                            is_fast <= (rx_byte == 8'h0B);
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    ADDR: if (rise) begin
                        sr <= {sr[SR_W-2:0], mosi};
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            ptr     <= {sr[MEM_ADDR_W-2:0], mosi};
`ifdef PSRAM_FAST_READ_EN
                            dummy_cnt <= '0;
                            state     <= is_write ? WRITE : (is_fast ? DUMMY : READ);
`else
                            state     <= is_write ? WRITE : READ;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
`ifdef PSRAM_FAST_READ_EN
                    DUMMY: if (rise) begin
                        if (dummy_cnt == 16'(DUMMY_CYCLES - 1)) state <= READ;
                        dummy_cnt <= dummy_cnt + 16'd1;
                    end
`endif
                    WRITE: if (rise) begin
                        sr <= {sr[SR_W-2:0], mosi};
                        if (bit_cnt == 5'd7) begin
                            bit_cnt    <= '0;
                            ptr        <= ptr + MEM_ADDR_W'(1);
                            byte_count <= count_inc;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    // bit_cnt counts bits already driven; 0 means the first byte is still pending.
                    // ptr runs one byte ahead so rd_q already holds the next byte at each load.
                    READ: if (fall) begin
                        if (bit_cnt == 5'd0 || bit_cnt == 5'd8) begin
                            serial_out <= rd_q[7];
                            tx         <= rd_q[6:0];
                            ptr        <= ptr + MEM_ADDR_W'(1);
                            bit_cnt    <= 5'd1;
                            if (bit_cnt == 5'd8) byte_count <= count_inc;
                        end else begin
                            serial_out <= tx[6];
                            tx         <= {tx[5:0], 1'b0};
                            bit_cnt    <= bit_cnt + 5'd1;
                        end
                    end
                    IGNORE: serial_out <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= rx_byte;
        rd_q <= mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) bd_data <= '0;
        else       bd_data <= mem[bd_addr];
    end
endmodule

// File: tb/tb_psram_spi_responder.sv
// tb/tb_psram_spi_responder.sv - randomized bench for psram_spi_responder against a byte-array memory model
module tb_psram_spi_responder;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        chip_enable = 1'b1;
    logic        serial_in = 1'b0;
    logic        serial_out;
    logic [9:0]  bd_addr = '0;
    logic [7:0]  bd_data;
    logic        busy;
    logic        bad_cmd;
    logic [15:0] byte_count;

    psram_spi_responder #(.MEM_ADDR_W(10), .DUMMY_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .chip_enable(chip_enable),
        .serial_in(serial_in), .serial_out(serial_out), .bd_addr(bd_addr),
        .bd_data(bd_data), .busy(busy), .bad_cmd(bad_cmd), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         bad_seen = 0;
    logic [7:0] ref_mem [1024];
    logic [7:0] wbuf [64];

    always @(negedge clk) if (bad_cmd) bad_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
        rxb = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            serial_in = txb[i];
            half_wait();
            rxb[i] = serial_out;
            sclk = 1'b1;
            half_wait();
            sclk = 1'b0;
        end
    endtask

    task automatic start_cmd(input logic [7:0] op);
        logic [7:0] d;
        chip_enable = 1'b0;
        repeat (4) @(negedge clk);
        xfer_bits(op, 8, d);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] d;
        xfer_bits(a[23:16], 8, d);
        xfer_bits(a[15:8], 8, d);
        xfer_bits(a[7:0], 8, d);
    endtask

    task automatic end_txn();
        half_wait();
        chip_enable = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic bd_check(input string tag, input logic [9:0] a, input logic [7:0] exp);
        bd_addr = a;
        @(negedge clk);
        check(tag, bd_data, exp);
    endtask

    task automatic spi_write(input logic [23:0] a, input int n);
        logic [7:0] d;
        logic [9:0] p;
        p = a[9:0];
        start_cmd(8'h02);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            xfer_bits(wbuf[i], 8, d);
            ref_mem[p] = wbuf[i];
            p++;
        end
        end_txn();
        check("wr_byte_count", byte_count, n);
    endtask

    task automatic spi_read(input string tag, input logic [23:0] a, input int n);
        logic [7:0] d;
        logic [9:0] p;
        p = a[9:0];
        start_cmd(8'h03);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            xfer_bits(8'h00, 8, d);
            check(tag, d, ref_mem[p]);
            p++;
        end
        end_txn();
        check("rd_byte_count", byte_count, n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not end, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [23:0] a;
        int          b0, n;

        repeat (5) @(negedge clk);
        check("rst_serial_out", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_cmd", bad_cmd, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_bd_data", bd_data, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // page-wrapping write burst then backdoor readback
        for (int i = 0; i < 32; i++) wbuf[i] = 8'(i + 1);
        spi_write(24'h5CAFF8, 32);
        for (int i = 0; i < 8; i++) bd_check("bd_wrap_hi", 10'h3F8 + 10'(i), 8'(i + 1));
        for (int i = 0; i < 24; i++) bd_check("bd_wrap_lo", 10'(i), 8'(i + 9));

        spi_read("rd_wrap", 24'h0003F8, 16);

        // partial trailing byte is dropped
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h5A;
        spi_write(24'h000100, 2);
        start_cmd(8'h02);
        send_addr(24'h000100);
        xfer_bits(8'hAB, 8, d);
        xfer_bits(8'hC0, 4, d);
        half_wait();
        check("partial_busy_hi", busy, 1);
        chip_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("partial_busy_fall", busy, 0);
        repeat (5) @(negedge clk);
        ref_mem[10'h100] = 8'hAB;
        check("partial_byte_count", byte_count, 1);
        bd_check("partial_full", 10'h100, 8'hAB);
        bd_check("partial_next", 10'h101, 8'h5A);

        // unsupported opcode
        b0 = bad_seen;
        start_cmd(8'h9F);
        for (int i = 0; i < 4; i++) begin
            xfer_bits(8'($urandom), 8, d);
            check("ignore_miso", d, 0);
        end
        end_txn();
        check("bad_cmd_pulses", bad_seen - b0, 1);
        spi_read("rd_after_bad", 24'hFF03F8, 2);

        // fast read opcode
        b0 = bad_seen;
        start_cmd(8'h0B);
        send_addr(24'h000000);
        xfer_bits(8'h00, 8, d);
        xfer_bits(8'h00, 8, d);
        end_txn();
`ifdef PSRAM_FAST_READ_EN
        check("fast_read_data", d, ref_mem[0]);
        check("fast_read_no_bad", bad_seen - b0, 0);
`else
        check("fast_read_disabled_miso", d, 0);
        check("fast_read_disabled_bad", bad_seen - b0, 1);
`endif

        // random bursts, read back through an aliased upper address
        for (int t = 0; t < 6; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            spi_write(a, n);
            spi_read("rd_random", (24'($urandom) & 24'hFFFC00) | {14'd0, a[9:0]}, n);
            bd_check("bd_random", a[9:0], ref_mem[a[9:0]]);
        end

        // reset in the middle of the third byte of a read burst
        for (int i = 0; i < 3; i++) wbuf[i] = 8'hFF;
        spi_write(24'h000200, 3);
        bd_addr = 10'h200;
        start_cmd(8'h03);
        send_addr(24'h000200);
        xfer_bits(8'h00, 8, d);
        xfer_bits(8'h00, 8, d);
        xfer_bits(8'h00, 3, d);
        check("pre_reset_miso", serial_out, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_serial_out", serial_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bad_cmd", bad_cmd, 0);
        check("midrst_byte_count", byte_count, 0);
        check("midrst_bd_data", bd_data, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_needs_ce_toggle", busy, 0);
        chip_enable = 1'b1;
        repeat (8) @(negedge clk);
        bd_check("mem_kept_after_rst", 10'h200, 8'hFF);
        spi_read("rd_after_rst", 24'h000200, 3);
        spi_read("rd_after_rst_wrap", 24'h0003FE, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
